// File: rtl/program_dumper_if.sv
// Dump request, memory read port and outgoing byte stream of program_dumper.
// master = dumper side, slave = requester/memory/sink side.
interface program_dumper_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       word_len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, word_len, mem_rdata, mem_rvalid, out_ready,
        output mem_addr, mem_re, out_data, out_valid, busy, done
    );
    modport slave (
        output start, base_addr, word_len, mem_rdata, mem_rvalid, out_ready,
        input  mem_addr, mem_re, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/program_dumper.sv
// Reads a block of 32-bit words and streams it out as little-endian bytes.
// Optional DUMP_CHECKSUM_EN appends the 32-bit word sum as a 4-byte trailer.
module program_dumper #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    program_dumper_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [CW-1:0]     outst, fifo_cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [31:0]       ser_word, load_word;
    logic [1:0]        ser_idx;
    logic [7:0]        out_data_q;
    logic              out_valid_q;
    logic              issue, rsp, ser_free, fifo_empty, bypass, pop, fifo_wr, csum_load;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0] csum;
    logic        csum_sent;
    assign csum_load = (state == S_CSUM) && !csum_sent && !out_valid_q;
`else
    assign csum_load = 1'b0;
`endif

    // Serialiser word does not consume a credit; outstanding + buffered does.
    assign fifo_empty = (fifo_cnt == '0);
    assign issue      = (state == S_READ) && (remaining != 16'd0) &&
                        (({1'b0, outst} + {1'b0, fifo_cnt}) < CREDITS);
    assign rsp        = bus.mem_rvalid && (outst != '0);
    assign ser_free   = !out_valid_q || (bus.out_ready && ser_idx == 2'd3);
    assign bypass     = rsp && fifo_empty && ser_free;
    assign pop        = ser_free && !fifo_empty;
    assign fifo_wr    = rsp && !bypass;

    assign bus.mem_addr  = addr;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        state_nxt  = state;
        bus.mem_re = issue;
        bus.busy   = (state != S_IDLE);
        bus.done   = (state == S_DONE);
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = (bus.word_len == 16'd0) ? S_DRAIN : S_READ;
            S_READ:  if (issue && remaining == 16'd1) state_nxt = S_DRAIN;
            S_DRAIN: if (outst == '0 && fifo_empty && !out_valid_q)
`ifdef DUMP_CHECKSUM_EN
                         state_nxt = S_CSUM;
            S_CSUM:  if (csum_sent && !out_valid_q) state_nxt = S_DONE;
`else
                         state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load_word = pop ? fifo_mem[rd_ptr] : bus.mem_rdata;
`ifdef DUMP_CHECKSUM_EN
        if (csum_load) load_word = csum;
`endif
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            outst       <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ser_word    <= '0;
            ser_idx     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) begin
                addr      <= bus.base_addr & ~ADDR_W'(3);
                remaining <= bus.word_len;
            end else if (issue) begin
                addr      <= addr + ADDR_W'(4);
                remaining <= remaining - 16'd1;
            end
            case ({issue, rsp})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: ;
            endcase
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            // A new word replaces the last byte in the same cycle it is taken.
            if (pop || bypass || csum_load) begin
                ser_word    <= load_word;
                ser_idx     <= 2'd0;
                out_data_q  <= load_word[7:0];
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                if (ser_idx == 2'd3) begin
                    out_valid_q <= 1'b0;
                end else begin
                    ser_idx    <= ser_idx + 2'd1;
                    out_data_q <= ser_word[{ser_idx + 2'd1, 3'b000} +: 8];
                end
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && bus.start)) begin
            csum      <= '0;
            csum_sent <= 1'b0;
        end else begin
            if (rsp)       csum      <= csum + bus.mem_rdata;
            if (csum_load) csum_sent <= 1'b1;
        end
    end
`endif

endmodule
